cc_rr_encoder: RTL and testbench



---
 rtl/cc_rr_encoder_pkg.sv | 18 +
 rtl/cc_rr_encoder_if.sv | 25 ++
 rtl/cc_rr_pick.sv | 42 ++++
 rtl/cc_rr_encoder.sv | 83 ++++++++
 tb/tb_cc_rr_encoder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_rr_encoder_pkg.sv
// Shared definitions for the round-robin encoder: FSM state encoding and the
// index-width helper used to derive IDX_WIDTH from a requester count.
package cc_rr_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index width needed to address n requesters; never less than one bit.
  function automatic int idx_width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_REQ_WIDTH = 8;
  localparam int DEF_IDX_WIDTH = idx_width_for(DEF_REQ_WIDTH);

endpackage

// File: rtl/cc_rr_encoder_if.sv
// Request/grant bundle between the requesters (master) and the encoder (slave).
interface cc_rr_encoder_if
  import cc_rr_encoder_pkg::*;
#(
  parameter int REQ_WIDTH = DEF_REQ_WIDTH,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
);

  logic [REQ_WIDTH-1:0] req;
  logic                 done;
  logic                 grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic [REQ_WIDTH-1:0] grant_onehot;

  modport master (
    output req, done,
    input  grant_valid, grant_idx, grant_onehot
  );

  modport slave (
    input  req, done,
    output grant_valid, grant_idx, grant_onehot
  );

endinterface

// File: rtl/cc_rr_pick.sv
// Circular priority search: rotate req so ptr lands at bit 0, find the lowest
// set bit, then add ptr back (mod REQ_WIDTH) to recover the absolute index.
module cc_rr_pick #(
  parameter int REQ_WIDTH = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic [REQ_WIDTH-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] winner_idx
);

  localparam logic [IDX_WIDTH:0] REQ_W_EXT = (IDX_WIDTH+1)'(REQ_WIDTH);

  logic [2*REQ_WIDTH-1:0] req_dbl;
  logic [REQ_WIDTH-1:0]   req_rot;
  logic [IDX_WIDTH-1:0]   offset;
  logic [IDX_WIDTH:0]     sum;

  assign req_dbl = {req, req};
  assign req_rot = REQ_WIDTH'(req_dbl >> ptr);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    // Descending scan: the last hit written is the lowest set bit.
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found  = 1'b1;
        offset = IDX_WIDTH'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= REQ_W_EXT) begin
      sum = sum - REQ_W_EXT;
    end
    winner_idx = sum[IDX_WIDTH-1:0];
  end

endmodule

// File: rtl/cc_rr_encoder.sv
// Registered round-robin arbiter/encoder: grants one requester until it
// signals done, then rotates priority past it so every requester gets a turn.
module cc_rr_encoder
  import cc_rr_encoder_pkg::*;
#(
  parameter int REQ_WIDTH = DEF_REQ_WIDTH,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input logic             clk,
  input logic             reset,
  cc_rr_encoder_if.slave  bus
);

  if (REQ_WIDTH > (1 << IDX_WIDTH)) begin : g_bad_width
    $error("IDX_WIDTH too narrow for REQ_WIDTH");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REQ_WIDTH - 1);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                 valid_q, valid_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [REQ_WIDTH-1:0] onehot_q, onehot_d;
  logic                 found;
  logic [IDX_WIDTH-1:0] winner;

  cc_rr_pick #(
    .REQ_WIDTH (REQ_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .found      (found),
    .winner_idx (winner)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    // Arbitrate when free, or when the owner releases; done while idle is moot.
    if (state_q == IDLE || bus.done) begin
      if (found) begin
        state_d  = GRANT;
        valid_d  = 1'b1;
        idx_d    = winner;
        onehot_d = REQ_WIDTH'(1) << winner;
        ptr_d    = (winner == LAST_IDX) ? '0 : winner + 1'b1;
      end else begin
        // grant_idx deliberately keeps the last owner.
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.grant_valid  = valid_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_onehot = onehot_q;

endmodule

// File: tb/tb_cc_rr_encoder.sv
// Self-checking bench for cc_rr_encoder: an 8-requester and a 5-requester
// instance run side by side against a circular-search reference model.
module tb_cc_rr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cc_rr_encoder_if #(.REQ_WIDTH(8), .IDX_WIDTH(3)) if8 ();
  cc_rr_encoder_if #(.REQ_WIDTH(5), .IDX_WIDTH(3)) if5 ();

  cc_rr_encoder #(.REQ_WIDTH(8), .IDX_WIDTH(3)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (if8.slave)
  );

  cc_rr_encoder #(.REQ_WIDTH(5), .IDX_WIDTH(3)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (if5.slave)
  );

  // Reference state per instance: [0] = 8-wide, [1] = 5-wide.
  bit m_valid [2];
  int m_idx   [2];
  int m_ptr   [2];

  function automatic int ref_pick(input int w, input int ptr, input logic [7:0] r);
    for (int k = 0; k < w; k++) begin
      int i;
      i = (ptr + k) % w;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input int d, input int w, input logic [7:0] r,
                              input logic dn, input logic rs);
    int p;
    if (rs) begin
      m_valid[d] = 1'b0;
      m_idx[d]   = 0;
      m_ptr[d]   = 0;
    end else if (!m_valid[d] || dn) begin
      p = ref_pick(w, m_ptr[d], r);
      if (p >= 0) begin
        m_valid[d] = 1'b1;
        m_idx[d]   = p;
        m_ptr[d]   = (p + 1) % w;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [11:0] exp8();
    logic [7:0] oh;
    oh = m_valid[0] ? 8'(1 << m_idx[0]) : 8'h00;
    return {m_valid[0], 3'(m_idx[0]), oh};
  endfunction

  function automatic logic [8:0] exp5();
    logic [4:0] oh;
    oh = m_valid[1] ? 5'(1 << m_idx[1]) : 5'h00;
    return {m_valid[1], 3'(m_idx[1]), oh};
  endfunction

  // Drive one cycle on both instances; returns after the following negedge.
  task automatic step(input logic [7:0] r8, input logic d8,
                      input logic [4:0] r5, input logic d5, input logic rs);
    if8.req  = r8;
    if8.done = d8;
    if5.req  = r5;
    if5.done = d5;
    reset    = rs;
    @(posedge clk);
    model_update(0, 8, r8, d8, rs);
    model_update(1, 5, {3'b000, r5}, d5, rs);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0, 5'h00, 1'b0, i < 2);
      checks++;
      if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== 12'h000) begin
        errors++;
        $display("FAIL reset8 cyc%0d: got v=%b idx=%0d oh=%h, want all zero",
                 i, if8.grant_valid, if8.grant_idx, if8.grant_onehot);
      end
      checks++;
      if ({if5.grant_valid, if5.grant_idx, if5.grant_onehot} !== 9'h000) begin
        errors++;
        $display("FAIL reset5 cyc%0d: got v=%b idx=%0d oh=%h, want all zero",
                 i, if5.grant_valid, if5.grant_idx, if5.grant_onehot);
      end
    end
  endtask

  task automatic test_hold_release();
    step(8'h00, 1'b0, 5'h00, 1'b0, 1'b1);
    step(8'h10, 1'b0, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd4, 8'h10}) begin
      errors++;
      $display("FAIL grant4: got v=%b idx=%0d oh=%h, want v=1 idx=4 oh=10",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0, 5'h00, 1'b0, 1'b0);
      checks++;
      if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd4, 8'h10}) begin
        errors++;
        $display("FAIL hold4 cyc%0d: got v=%b idx=%0d oh=%h, want v=1 idx=4 oh=10",
                 i, if8.grant_valid, if8.grant_idx, if8.grant_onehot);
      end
    end
    step(8'h00, 1'b1, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b0, 3'd4, 8'h00}) begin
      errors++;
      $display("FAIL release4: got v=%b idx=%0d oh=%h, want v=0 idx=4 oh=00",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
    // done while idle must not start anything.
    step(8'h00, 1'b1, 5'h00, 1'b1, 1'b0);
    checks++;
    if (if8.grant_valid !== 1'b0 || if5.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: got v8=%b v5=%b, want 0 0",
               if8.grant_valid, if5.grant_valid);
    end
  endtask

  // All requesters active with done every cycle, on both widths.
  task automatic test_back_to_back();
    step(8'h00, 1'b0, 5'h00, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      step(8'hFF, 1'b1, 5'h1F, 1'b1, 1'b0);
      checks++;
      if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !==
          {1'b1, 3'(k % 8), 8'(1 << (k % 8))}) begin
        errors++;
        $display("FAIL rr8 k=%0d: got v=%b idx=%0d oh=%h, want v=1 idx=%0d",
                 k, if8.grant_valid, if8.grant_idx, if8.grant_onehot, k % 8);
      end
      checks++;
      if ({if5.grant_valid, if5.grant_idx, if5.grant_onehot} !==
          {1'b1, 3'(k % 5), 5'(1 << (k % 5))}) begin
        errors++;
        $display("FAIL rr5 k=%0d: got v=%b idx=%0d oh=%h, want v=1 idx=%0d",
                 k, if5.grant_valid, if5.grant_idx, if5.grant_onehot, k % 5);
      end
    end
  endtask

  task automatic test_wrap();
    step(8'h00, 1'b0, 5'h00, 1'b0, 1'b1);
    step(8'h20, 1'b0, 5'h00, 1'b0, 1'b0);
    checks++;
    if (if8.grant_idx !== 3'd5 || if8.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_first: got v=%b idx=%0d, want v=1 idx=5",
               if8.grant_valid, if8.grant_idx);
    end
    step(8'h03, 1'b1, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL wrap_to0: got v=%b idx=%0d oh=%h, want v=1 idx=0 oh=01",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
    step(8'h03, 1'b1, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd1, 8'h02}) begin
      errors++;
      $display("FAIL wrap_to1: got v=%b idx=%0d oh=%h, want v=1 idx=1 oh=02",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
  endtask

  task automatic test_reset_mid_grant();
    step(8'h00, 1'b0, 5'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 5'h00, 1'b0, 1'b0);
    checks++;
    if (if8.grant_idx !== 3'd3 || if8.grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant3: got v=%b idx=%0d, want v=1 idx=3",
               if8.grant_valid, if8.grant_idx);
    end
    step(8'h08, 1'b0, 5'h00, 1'b0, 1'b1);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: got v=%b idx=%0d oh=%h, want all zero",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
    step(8'h81, 1'b0, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      errors++;
      $display("FAIL post_reset0: got v=%b idx=%0d oh=%h, want v=1 idx=0 oh=01",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
    step(8'h81, 1'b1, 5'h00, 1'b0, 1'b0);
    checks++;
    if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== {1'b1, 3'd7, 8'h80}) begin
      errors++;
      $display("FAIL post_reset7: got v=%b idx=%0d oh=%h, want v=1 idx=7 oh=80",
               if8.grant_valid, if8.grant_idx, if8.grant_onehot);
    end
  endtask

  task automatic test_random();
    step(8'h00, 1'b0, 5'h00, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r8;
      logic [4:0] r5;
      r8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r5 = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      step(r8, 1'($urandom_range(0, 1)), r5, 1'($urandom_range(0, 1)),
           $urandom_range(0, 59) == 0);
      checks++;
      if ({if8.grant_valid, if8.grant_idx, if8.grant_onehot} !== exp8()) begin
        errors++;
        $display("FAIL rand8 i=%0d: got %h, want %h (v,idx,oh)",
                 i, {if8.grant_valid, if8.grant_idx, if8.grant_onehot}, exp8());
      end
      checks++;
      if ({if5.grant_valid, if5.grant_idx, if5.grant_onehot} !== exp5() ||
          if5.grant_idx > 3'd4) begin
        errors++;
        $display("FAIL rand5 i=%0d: got %h, want %h (v,idx,oh)",
                 i, {if5.grant_valid, if5.grant_idx, if5.grant_onehot}, exp5());
      end
    end
  endtask

  initial begin
    if8.req  = '0;
    if8.done = 1'b0;
    if5.req  = '0;
    if5.done = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold_release();
    test_back_to_back();
    test_wrap();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
